// File: rtl/rs_issue_scheduler.sv
// rs_issue_scheduler: picks up to N_WAY ready reservation-station entries per cycle, one multiply at most
// Ports: i_clock/i_reset (sync, active-high)/i_flush; i_rs_ready, i_rs_is_mult, i_rs_order_idx per entry;
//        o_issue_valid/o_issue_rs_idx per lane, o_issue_num (popcount), o_mult_busy.
// Macro RS_SCHED_AGE_EN: oldest-first by order_idx when defined, lowest entry index first otherwise.
module rs_issue_scheduler #(
  parameter int N_RS       = 8,
  parameter int N_WAY      = 3,
  parameter int ORDER_BITS = 6,
  parameter int MULT_LAT   = 4
) (
  input  logic                                    i_clock,
  input  logic                                    i_reset,
  input  logic                                    i_flush,
  input  logic [N_RS-1:0]                         i_rs_ready,
  input  logic [N_RS-1:0]                         i_rs_is_mult,
  input  logic [N_RS-1:0][ORDER_BITS-1:0]         i_rs_order_idx,
  output logic [N_WAY-1:0]                        o_issue_valid,
  output logic [N_WAY-1:0][$clog2(N_RS)-1:0]      o_issue_rs_idx,
  output logic [$clog2(N_WAY):0]                  o_issue_num,
  output logic                                    o_mult_busy
);
  localparam int IW = $clog2(N_RS);
  localparam int NW = $clog2(N_WAY) + 1;
  localparam int CW = $clog2(MULT_LAT + 1);
`ifdef RS_SCHED_AGE_EN
  localparam bit AGE = 1'b1;
`else
  localparam bit AGE = 1'b0;
`endif
  logic [N_WAY-1:0]         r_valid, w_valid;
  logic [N_WAY-1:0][IW-1:0] r_idx, w_idx;
  logic [NW-1:0]            r_num, w_num;
  logic [N_RS-1:0]          r_mask, w_mask, w_avail;
  logic                     r_mult, w_mult, w_found, w_blocked;
  logic [CW-1:0]            r_cnt;
  logic [IW-1:0]            w_best;
  assign w_blocked      = (r_cnt != '0) || r_mult;
  assign o_issue_valid  = r_valid;
  assign o_issue_rs_idx = r_idx;
  assign o_issue_num    = r_num;
  assign o_mult_busy    = r_cnt != '0;
  // Each lane takes the best remaining candidate; once a multiply is taken, other multiplies are passed over.
  always_comb begin
    w_avail = i_rs_ready & ~r_mask & ~(i_rs_is_mult & {N_RS{w_blocked}});
    w_valid = '0;
    w_idx   = '0;
    w_num   = '0;
    w_mask  = '0;
    w_mult  = 1'b0;
    w_found = 1'b0;
    w_best  = '0;
    for (int k = 0; k < N_WAY; k++) begin
      w_found = 1'b0;
      w_best  = '0;
      for (int i = 0; i < N_RS; i++)
        if (w_avail[i] && !(i_rs_is_mult[i] && w_mult) &&
            (!w_found || (AGE && i_rs_order_idx[i] < i_rs_order_idx[w_best]))) begin
          w_best  = IW'(i);
          w_found = 1'b1;
        end
      if (w_found) begin
        w_valid[k]      = 1'b1;
        w_idx[k]        = w_best;
        w_avail[w_best] = 1'b0;
        w_mask[w_best]  = 1'b1;
        w_mult          = w_mult | i_rs_is_mult[w_best];
        w_num           = w_num + NW'(1);
      end
    end
  end
  always_ff @(posedge i_clock) begin
    if (i_reset || i_flush) begin
      r_valid <= '0;
      r_idx   <= '0;
      r_num   <= '0;
      r_mask  <= '0;
      r_mult  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_valid <= w_valid;
      r_idx   <= w_idx;
      r_num   <= w_num;
      r_mask  <= w_mask;
      r_mult  <= w_mult;
      r_cnt   <= w_mult ? CW'(MULT_LAT - 1) : (r_cnt != '0 ? r_cnt - 1'b1 : '0);
    end
  end
endmodule

// File: doc/rs_issue_scheduler.md
RS_ISSUE_SCHEDULER -- requirements
Module: rs_issue_scheduler

Interface
REQ-001 The block SHALL take parameter N_RS, default 8: number of reservation station entries arbitrated.
REQ-002 The block SHALL take parameter N_WAY, default 3: issue lanes per cycle.
REQ-003 The block SHALL take parameter ORDER_BITS, default 6: width of the entry age tag (order_idx).
REQ-004 The block SHALL take parameter MULT_LAT, default 4: cycles the single non-pipelined multiplier stays busy per grant.
REQ-005 clock  input  1  Sole clock; all state updates on the rising edge.
REQ-006 reset  input  1  Synchronous, active-high reset, sampled on the rising edge of clock.
REQ-007 flush  input  1  Squash; clears in-flight grants and multiplier occupancy.
REQ-008 rs_ready  input  N_RS  Entry i is busy with both source tags ready.
REQ-009 rs_is_mult  input  N_RS  Entry i needs the multiplier.
REQ-010 rs_order_idx  input  N_RS x ORDER_BITS  Dispatch age of entry i; smaller is older.
REQ-011 issue_valid  output  N_WAY  Lane k carries a grant this cycle.
REQ-012 issue_rs_idx  output  N_WAY x clog2(N_RS)  Entry granted on lane k.
REQ-013 issue_num  output  clog2(N_WAY)+1  Count of set issue_valid bits.
REQ-014 mult_busy  output  1  Multiplier occupied; no multiply grant possible.

Function
REQ-015 Each cycle the block SHALL select up to N_WAY eligible entries; eligible = rs_ready & ~grant_mask & ~(rs_is_mult & mult_blocked).
REQ-016 Selection SHALL be registered: selections made in cycle t appear on issue_* in cycle t+1 (latency 1).
REQ-017 Lanes SHALL fill contiguously from lane 0; lane k granted only if lane k-1 granted.
REQ-018 Ordering among eligible entries SHALL follow the REQ-033 rule; ties on order_idx go to the lower entry index.
REQ-019 At most one entry with rs_is_mult SHALL be selected per cycle; further multiply entries are skipped, not blocking younger non-multiply entries.
REQ-020 grant_mask SHALL hold the entries selected in the previous cycle, so an entry is never granted in two consecutive cycles.
REQ-021 A multiply selection SHALL load a down-counter with MULT_LAT-1 when the grant is output; mult_busy SHALL be 1 while the counter is nonzero.
REQ-022 mult_blocked SHALL be true when mult_busy is 1 or a multiply is selected in the current cycle's registered output.
REQ-023 Fewer eligible entries than N_WAY SHALL leave the upper lanes invalid with issue_rs_idx 0.
REQ-024 No eligible entries SHALL produce issue_valid all-zero and issue_num 0.
REQ-025 flush SHALL, at the next edge, zero issue_valid, issue_num, grant_mask and the multiplier counter; inputs during the flush cycle are ignored.
REQ-026 flush and reset both asserted SHALL behave as reset.
REQ-027 issue_num SHALL always equal the popcount of issue_valid.

Reset
REQ-028 On reset the block SHALL set issue_valid to 0, issue_rs_idx to 0, issue_num to 0 and mult_busy to 0 at the next edge.
REQ-029 On reset the block SHALL clear grant_mask and the multiplier counter.
REQ-030 Reset asserted mid-multiply SHALL abandon the occupancy, and a multiply SHALL be grantable in the first cycle after release.
REQ-031 While reset is held, the block SHALL produce no grants.

Configuration
REQ-032 The block SHALL use macro RS_SCHED_AGE_EN to select the ordering rule.
REQ-033 With RS_SCHED_AGE_EN defined, selection SHALL be oldest-first by rs_order_idx; without it, selection SHALL be fixed priority by lowest entry index, with rs_order_idx ignored.

Verification
REQ-034 Bench SHALL cover age order: ready entries 2,5,6 with order 9,3,7, AGE_EN on -> lanes 0..2 = 5,6,2 and issue_num 3 one cycle later.
REQ-035 Bench SHALL cover excess ready: entries 0..4 ready with equal order -> grants 0,1,2; next cycle, with 0..2 still ready, grants 3,4 and issue_num 2.
REQ-036 Bench SHALL cover multiply occupancy: multiply entries 1 and 3 ready plus ALU entry 4 -> grants 1,4; mult_busy high for 3 cycles; entry 3 granted in the cycle mult_busy falls.
REQ-037 Bench SHALL cover flush: flush with entries 0,1 ready and mult_busy high -> next cycle issue_valid 0 and mult_busy 0.
REQ-038 Bench SHALL cover fixed priority: AGE_EN undefined, entries 6,1,4 ready with order 1,9,5 -> lanes 1,4,6.
REQ-039 Bench SHALL cover reset mid-multiply: reset during mult_busy, release with multiply entry 2 ready -> entry 2 granted one cycle after release.
